pulse_voice: RTL
================

Name: pulse_voice

Overview:
- Downstream consumer of the note sequencer's note code and new-note event; turns each 6-bit note into an audible pulse-wave channel.
- Maps the note code to an 11-bit timer period through an internal period ROM.
- Runs an APU-style period down-counter and 8-step duty sequencer, with a linear decay envelope.
- Emits a 4-bit amplitude sample to the mixer/DAC stage.

Parameters:
- P_ENV_START, 15, envelope volume loaded on each new note (0..15).
- P_DECAY, 1, 1 = volume decrements on each i_env_stb; 0 = volume held constant.
- P_MIN_PERIOD, 8, looked-up periods below this value play as silence (ultrasonic guard).

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_note  in  6  note code; 0 = rest, 1..63 = pitch index into the period table.
- i_note_valid  in  1  one-cycle strobe; sample i_note and start a new note.
- i_tick  in  1  timer clock-enable, one cycle wide (e.g. 894886 Hz).
- i_env_stb  in  1  envelope step strobe (e.g. 240 Hz), one cycle wide.
- i_duty  in  2  duty select, sampled on i_note_valid: 00=12.5%, 01=25%, 10=50%, 11=75%.
- o_sample  out  4  registered amplitude sample.
- o_active  out  1  high while a pitched note plays with volume > 0.

Behaviour:
- Reset:
  - state = IDLE; timer, period, step, volume = 0.
  - o_sample = 0, o_active = 0.
- Reset mid-note forces all of the above on the next edge, regardless of the other inputs.
- FSM states: IDLE, LOAD, RUN.
  - Any state, i_note_valid = 1: latch note code and i_duty; present the note to the ROM address register; go to LOAD. i_tick and i_env_stb are ignored in that cycle.
  - LOAD, one cycle, ROM data valid:
    - period <= rom[note]; timer <= rom[note]; step <= 0; volume <= P_ENV_START.
    - If note == 0 or rom period < P_MIN_PERIOD, go to IDLE with volume = 0. Otherwise go to RUN.
    - i_tick and i_env_stb are ignored in LOAD.
  - RUN:
    - On i_tick: if timer == 0, then timer <= period and step <= step + 1 (mod 8, wraps 7 -> 0); otherwise timer <= timer - 1.
    - Resulting tone frequency = f_tick / (8 * (period + 1)).
    - On i_env_stb with P_DECAY = 1 and volume > 0: volume <= volume - 1. Volume saturates at 0.
    - When volume reaches 0, go to IDLE.
  - IDLE: timer frozen, o_sample = 0.
- Simultaneous events:
  - i_note_valid has priority over i_tick and i_env_stb.
  - i_tick and i_env_stb in the same RUN cycle are both applied.
- Duty patterns, bit = step index:
  - 00: 8'b0000_0001
  - 01: 8'b0000_0011
  - 10: 8'b0000_1111
  - 11: 8'b1111_1100
- Output stage, registered:
  - o_sample <= (state == RUN && pattern[step]) ? volume : 0.
  - o_active <= (state == RUN && volume != 0).
- Latency: i_note_valid at cycle N gives LOAD at N+1, RUN at N+2, and the first o_sample for step 0 at N+3.
- Retrigger: i_note_valid during RUN restarts immediately. Step is reset and there is no glitch-free phase continuation.
- Widths: timer and period are 11 bits unsigned; step 3 bits; volume 4 bits. No arithmetic exceeds these widths.

Decomposition:
- Package pulse_voice_pkg holds:
  - NOTE_W = 6, PERIOD_W = 11, VOL_W = 4.
  - Duty pattern constants.
  - FSM state enum.
  - The 64-entry period table as a constant function. Entry 0 = 0; entry 46 (A4) = 253; entries derived from f_tick = 894886 Hz in 12-TET.
- Sub-module note_period_rom: registered 64x11 lookup (address in, data out one cycle later). Maps to LUTs or BRAM.

Test Plan:
- Reset, then note 46, duty 10 -> LOAD one cycle, then RUN. Step advances every 254 i_tick pulses. o_sample = 15 for steps 0-3 and 0 for steps 4-7.
- Duty 00, note 46 -> o_sample is nonzero only during step 0 (254 ticks out of every 2032). Duty 11 -> zero only during steps 0-1.
- Note 46, P_DECAY = 1, 15 i_env_stb pulses -> volume steps 15 to 0. o_active drops the cycle after volume reaches 0; state = IDLE; o_sample = 0.
- Note 0 (rest), or a note whose table entry < 8 -> LOAD, then IDLE. o_active stays 0 and o_sample stays 0.
- i_note_valid with note 20, coincident with i_tick and i_env_stb, during RUN of note 46 -> both strobes ignored; timer reloads rom[20]; step = 0; volume = 15.
- i_rst asserted mid-RUN together with i_note_valid -> next cycle state = IDLE, o_sample = 0, o_active = 0, and no LOAD follows.

Source files
------------

// File: rtl/pulse_voice_pkg.sv
// Shared widths, duty patterns, FSM encoding and the note-to-period table for the pulse voice.
// Periods are round(894886 / (8 * f_note)) - 1 in 12-TET with note 46 = A4 = 440 Hz.
package pulse_voice_pkg;

    localparam int NOTE_W   = 6;
    localparam int PERIOD_W = 11;
    localparam int VOL_W    = 4;

    localparam logic [7:0] DUTY_12 = 8'b0000_0001;
    localparam logic [7:0] DUTY_25 = 8'b0000_0011;
    localparam logic [7:0] DUTY_50 = 8'b0000_1111;
    localparam logic [7:0] DUTY_75 = 8'b1111_1100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    function automatic logic [7:0] duty_pattern(input logic [1:0] sel);
        logic [7:0] pat;
        case (sel)
            2'b00:   pat = DUTY_12;
            2'b01:   pat = DUTY_25;
            2'b10:   pat = DUTY_50;
            default: pat = DUTY_75;
        endcase
        return pat;
    endfunction

    // Notes 1..9 would need more than 11 bits and are clamped to the longest period.
    function automatic logic [PERIOD_W-1:0] period_lut(input logic [NOTE_W-1:0] n);
        logic [PERIOD_W-1:0] p;
        case (n)
            6'd0:  p = 11'd0;
            6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9: p = 11'd2047;
            6'd10: p = 11'd2033;  6'd11: p = 11'd1919;  6'd12: p = 11'd1811;
            6'd13: p = 11'd1709;  6'd14: p = 11'd1613;  6'd15: p = 11'd1523;
            6'd16: p = 11'd1437;  6'd17: p = 11'd1356;  6'd18: p = 11'd1280;
            6'd19: p = 11'd1208;  6'd20: p = 11'd1140;  6'd21: p = 11'd1076;
            6'd22: p = 11'd1016;  6'd23: p = 11'd959;   6'd24: p = 11'd905;
            6'd25: p = 11'd854;   6'd26: p = 11'd806;   6'd27: p = 11'd761;
            6'd28: p = 11'd718;   6'd29: p = 11'd678;   6'd30: p = 11'd640;
            6'd31: p = 11'd604;   6'd32: p = 11'd570;   6'd33: p = 11'd538;
            6'd34: p = 11'd507;   6'd35: p = 11'd479;   6'd36: p = 11'd452;
            6'd37: p = 11'd427;   6'd38: p = 11'd403;   6'd39: p = 11'd380;
            6'd40: p = 11'd359;   6'd41: p = 11'd338;   6'd42: p = 11'd319;
            6'd43: p = 11'd301;   6'd44: p = 11'd284;   6'd45: p = 11'd268;
            6'd46: p = 11'd253;   6'd47: p = 11'd239;   6'd48: p = 11'd225;
            6'd49: p = 11'd213;   6'd50: p = 11'd201;   6'd51: p = 11'd189;
            6'd52: p = 11'd179;   6'd53: p = 11'd169;   6'd54: p = 11'd159;
            6'd55: p = 11'd150;   6'd56: p = 11'd142;   6'd57: p = 11'd134;
            6'd58: p = 11'd126;   6'd59: p = 11'd119;   6'd60: p = 11'd112;
            6'd61: p = 11'd106;   6'd62: p = 11'd100;   6'd63: p = 11'd94;
            default: p = 11'd0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/pulse_voice_rom.sv
// Registered 64x11 note-to-period lookup; the address is captured only when a new note arrives.
module note_period_rom
    import pulse_voice_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_en,
    input  logic [NOTE_W-1:0]   i_addr,
    output logic [PERIOD_W-1:0] o_data
);

    always_ff @(posedge i_clk) begin
        if (i_en)
            o_data <= period_lut(i_addr);
    end

endmodule

// File: rtl/pulse_voice.sv
// Pulse-wave voice: note code -> period lookup, period down-counter, 8-step duty sequencer
// and linear decay envelope, producing a registered 4-bit amplitude sample.
module pulse_voice
    import pulse_voice_pkg::*;
#(
    parameter int P_ENV_START  = 15,
    parameter int P_DECAY      = 1,
    parameter int P_MIN_PERIOD = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NOTE_W-1:0] i_note,
    input  logic              i_note_valid,
    input  logic              i_tick,
    input  logic              i_env_stb,
    input  logic [1:0]        i_duty,
    output logic [VOL_W-1:0]  o_sample,
    output logic              o_active
);

    state_t              state;
    state_t              state_d;
    logic [NOTE_W-1:0]   note_q;
    logic [1:0]          duty_q;
    logic [PERIOD_W-1:0] rom_data;
    logic [PERIOD_W-1:0] period;
    logic [PERIOD_W-1:0] timer;
    logic [2:0]          step;
    logic [VOL_W-1:0]    volume;
    logic [VOL_W-1:0]    volume_nxt;
    logic                silent;
    logic [VOL_W-1:0]    sample_d;
    logic                active_d;
    logic [7:0]          pattern;

    note_period_rom u_rom (
        .i_clk  (i_clk),
        .i_en   (i_note_valid),
        .i_addr (i_note),
        .o_data (rom_data)
    );

    // Rests and ultrasonic periods never enter RUN.
    assign silent  = (note_q == '0) || (rom_data < PERIOD_W'(P_MIN_PERIOD));
    assign pattern = duty_pattern(duty_q);

    always_comb begin
        volume_nxt = volume;
        if (i_env_stb && (P_DECAY != 0) && (volume != '0))
            volume_nxt = volume - VOL_W'(1);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)
            state <= ST_IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d = state;
        if (i_note_valid) begin
            state_d = ST_LOAD;
        end else begin
            case (state)
                ST_LOAD: state_d = silent ? ST_IDLE : ST_RUN;
                ST_RUN:  if (volume_nxt == '0) state_d = ST_IDLE;
                default: state_d = state;
            endcase
        end
    end

    always_comb begin
        sample_d = '0;
        active_d = 1'b0;
        if (state == ST_RUN) begin
            sample_d = pattern[step] ? volume : '0;
            active_d = (volume != '0);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            note_q <= '0;
            duty_q <= '0;
            period <= '0;
            timer  <= '0;
            step   <= '0;
            volume <= '0;
        end else if (i_note_valid) begin
            note_q <= i_note;
            duty_q <= i_duty;
        end else begin
            case (state)
                ST_LOAD: begin
                    period <= rom_data;
                    timer  <= rom_data;
                    step   <= '0;
                    volume <= silent ? '0 : VOL_W'(P_ENV_START);
                end
                ST_RUN: begin
                    if (i_tick) begin
                        if (timer == '0) begin
                            timer <= period;
                            step  <= step + 3'd1;
                        end else begin
                            timer <= timer - PERIOD_W'(1);
                        end
                    end
                    volume <= volume_nxt;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_sample <= '0;
            o_active <= 1'b0;
        end else begin
            o_sample <= sample_d;
            o_active <= active_d;
        end
    end

endmodule
